// File: rtl/lab6_pkg.sv
// Shared types and constants for the binary-to-digit loader.
package lab6_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int BIN_W      = 27;
    localparam int SEL_W      = $clog2(NUM_DIGITS);
    localparam int MAX_VAL    = 99_999_999;
    localparam logic [3:0] OVF_DIGIT = 4'hE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bin_to_digit_loader_if.sv
// Input handshake plus display-file write port of the loader.
interface bin_to_digit_loader_if
    import lab6_pkg::*;
#(
    parameter int BIN_W = lab6_pkg::BIN_W
);
    logic             in_valid;
    logic [BIN_W-1:0] in_data;
    logic             in_ready;
    logic [3:0]       num;
    logic [SEL_W-1:0] sel;
    logic             write;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (
        output in_valid, in_data,
        input  in_ready, num, sel, write, busy, done, overflow
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, num, sel, write, busy, done, overflow
    );
endinterface

// File: rtl/bin_to_digit_loader_dd_adjust.sv
// Double-dabble correction: every BCD nibble of 5 or more gets 3 added
// so the following left shift carries correctly into the next digit.
module dd_adjust #(
    parameter int NUM_DIGITS = 8
) (
    input  logic [NUM_DIGITS*4-1:0] bcd_in,
    output logic [NUM_DIGITS*4-1:0] bcd_out
);

    // Per-nibble add-3 rule.
    always_comb begin
        bcd_out = bcd_in;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_in[4*i +: 4] >= 4'd5) begin
                bcd_out[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
            end
        end
    end

endmodule

// File: rtl/bin_to_digit_loader.sv
// Accepts a binary value, converts it to BCD one bit per cycle and writes
// the digits into the display register file, least-significant first.
//
//   state | meaning
//   IDLE  | ready for a new value
//   CONV  | double-dabble shifting, one input bit per cycle
//   WRITE | one digit written per cycle, sel = 0 .. NUM_DIGITS-1
//   DONE  | single-cycle completion pulse
module bin_to_digit_loader
    import lab6_pkg::*;
#(
    parameter int NUM_DIGITS = lab6_pkg::NUM_DIGITS,
    parameter int BIN_W      = lab6_pkg::BIN_W
) (
    input  logic                  clk,
    input  logic                  reset,
    bin_to_digit_loader_if.slave  bus
);

    localparam int CNT_W = $clog2(BIN_W);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);

    state_t                  state;
    state_t                  state_nxt;
    logic [BIN_W-1:0]        bin;
    logic [NUM_DIGITS*4-1:0] bcd;
    logic [NUM_DIGITS*4-1:0] bcd_adj;
    logic [CNT_W-1:0]        bit_cnt;
    logic [IDX_W-1:0]        idx;
    logic                    ovf;
    logic                    accept;
    logic                    in_ovf;

    assign accept = bus.in_valid && (state == IDLE);
    // The full input width takes part in the range compare.
    assign in_ovf = (bus.in_data > MAX_BIN);

    dd_adjust #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_adjust (
        .bcd_in  (bcd),
        .bcd_out (bcd_adj)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = in_ovf ? WRITE : CONV;
            CONV:    if (bit_cnt == CNT_LAST) state_nxt = WRITE;
            WRITE:   if (idx == IDX_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Conversion datapath, digit index and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin     <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            idx     <= '0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bin     <= bus.in_data;
                        bcd     <= '0;
                        bit_cnt <= '0;
                        idx     <= '0;
                        ovf     <= in_ovf;
                    end
                end
                CONV: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    bit_cnt    <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_LAST) begin
                        idx <= '0;
                    end
                end
                WRITE: begin
                    idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Moore outputs; sel/num are held at zero outside WRITE.
    always_comb begin
        bus.in_ready = (state == IDLE);
        bus.busy     = (state != IDLE);
        bus.write    = (state == WRITE);
        bus.done     = (state == DONE);
        bus.overflow = ovf;
        bus.sel      = '0;
        bus.num      = 4'd0;
        if (state == WRITE) begin
            bus.sel = idx;
            bus.num = ovf ? OVF_DIGIT : bcd[4*idx +: 4];
        end
    end

endmodule

// File: tb/tb_bin_to_digit_loader.sv
// Directed bench for the binary-to-digit loader.
module tb_bin_to_digit_loader;
    import lab6_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    bin_to_digit_loader_if bus ();

    bin_to_digit_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for in_ready at a falling edge, then presents a value.
    task automatic drive_value(input logic [26:0] value);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(n < 100), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = value;
    endtask

    // One transaction; digits are packed with nibble i expected at sel=i.
    // Cycle 1 is the cycle after the acceptance edge.
    task automatic txn(input logic [26:0] value, input bit exp_ovf,
                       input logic [31:0] digits, input int first_wr,
                       input int done_cyc, input bit keep_valid,
                       input logic [26:0] later_data, input bit pre_accepted);
        int first_seen;
        int done_seen;
        int wr_cnt;
        int done_cnt;
        logic [31:0] d;
        first_seen = -1;
        done_seen  = -1;
        wr_cnt     = 0;
        done_cnt   = 0;
        d          = digits;
        if (!pre_accepted) drive_value(value);
        @(posedge clk);
        #1;
        if (!keep_valid) bus.in_valid = 1'b0;
        for (int cyc = 1; cyc <= done_cyc; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk);
                #1;
            end
            if (cyc == 1) begin
                check("ready_low", 32'(bus.in_ready), 32'd0);
                check("busy_high", 32'(bus.busy), 32'd1);
                check("ovf_flag", 32'(bus.overflow), 32'(exp_ovf));
            end
            if (cyc == 2 && keep_valid) bus.in_data = later_data;
            if (bus.write) begin
                if (first_seen < 0) first_seen = cyc;
                check("sel", 32'(bus.sel), 32'(cyc - first_wr));
                check("num", 32'(bus.num), 32'(d[4*((cyc - first_wr) & 7) +: 4]));
                wr_cnt++;
            end
            if (bus.done) begin
                if (done_seen < 0) done_seen = cyc;
                done_cnt++;
            end
        end
        check("first_wr", 32'(first_seen), 32'(first_wr));
        check("wr_cnt", 32'(wr_cnt), 32'd8);
        check("done_cyc", 32'(done_seen), 32'(done_cyc));
        check("done_cnt", 32'(done_cnt), 32'd1);
        check("ovf_hold", 32'(bus.overflow), 32'(exp_ovf));
    endtask

    initial begin
        int wr_cnt;
        int done_cnt;
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        #12;
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check("rst_write", 32'(bus.write), 32'd0);
        check("rst_sel", 32'(bus.sel), 32'd0);
        check("rst_num", 32'(bus.num), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        txn(27'd12_345_678, 1'b0, 32'h1234_5678, 28, 36, 1'b0, 27'd0, 1'b0);
        txn(27'd0,          1'b0, 32'h0000_0000, 28, 36, 1'b0, 27'd0, 1'b0);
        txn(27'd99_999_999, 1'b0, 32'h9999_9999, 28, 36, 1'b0, 27'd0, 1'b0);
        txn(27'd100_000_000, 1'b1, 32'hEEEE_EEEE, 1, 9, 1'b0, 27'd0, 1'b0);
        txn(27'h7FF_FFFF,   1'b1, 32'hEEEE_EEEE, 1, 9, 1'b0, 27'd0, 1'b0);
        txn(27'd10_000_001, 1'b0, 32'h1000_0001, 28, 36, 1'b0, 27'd0, 1'b0);

        // in_valid held high: 42 converts, 7 is taken after a one-cycle gap.
        txn(27'd42, 1'b0, 32'h0000_0042, 28, 36, 1'b1, 27'd7, 1'b0);
        @(posedge clk);
        #1;
        check("gap_idle", 32'(bus.in_ready), 32'd1);
        txn(27'd7, 1'b0, 32'h0000_0007, 28, 36, 1'b0, 27'd0, 1'b1);

        // Reset in the tenth CONV cycle.
        drive_value(27'd12_345_678);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rc_ready", 32'(bus.in_ready), 32'd1);
        check("rc_busy", 32'(bus.busy), 32'd0);
        check("rc_write", 32'(bus.write), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        wr_cnt   = 0;
        done_cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.write) wr_cnt++;
            if (bus.done) done_cnt++;
        end
        check("rc_no_write", 32'(wr_cnt), 32'd0);
        check("rc_no_done", 32'(done_cnt), 32'd0);
        txn(27'd5, 1'b0, 32'h0000_0005, 28, 36, 1'b0, 27'd0, 1'b0);

        // Reset mid-cycle during the third WRITE cycle.
        drive_value(27'd12_345_678);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        check("rw_pre_write", 32'(bus.write), 32'd1);
        check("rw_pre_sel", 32'(bus.sel), 32'd2);
        check("rw_pre_num", 32'(bus.num), 32'd6);
        #2;
        reset = 1'b1;
        #1;
        check("rw_write", 32'(bus.write), 32'd0);
        check("rw_sel", 32'(bus.sel), 32'd0);
        check("rw_num", 32'(bus.num), 32'd0);
        check("rw_done", 32'(bus.done), 32'd0);
        check("rw_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.write) done_cnt++;
        end
        check("rw_quiet", 32'(done_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_digit_loader.md
Name: bin_to_digit_loader

Overview:
Upstream feeder for the 8-digit seven-segment display register file. It accepts a binary value through a valid/ready handshake and converts it to 8 BCD digits with an iterative double-dabble engine, one shift per cycle. It then writes the digits into the display file over 8 consecutive cycles using the file's num/sel/write port. Inputs too large for 8 decimal digits are reported as overflow and displayed as "EEEEEEEE".

Parameters:
NUM_DIGITS, 8, number of display digits written; also the depth of the sel address space.
BIN_W, 27, binary input width; must be at least 27 to hold 99_999_999.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  in_data is valid
in_data  input  BIN_W  unsigned binary value to display
in_ready  output  1  block is idle and can accept a value
num  output  4  digit value to the display file
sel  output  3  digit address to the display file; 0 is the least-significant digit
write  output  1  write strobe to the display file
busy  output  1  conversion or write sequence in progress
done  output  1  one-cycle pulse after the last digit is written
overflow  output  1  sticky flag: last accepted value was greater than 99_999_999

Behaviour:
- Reset (asynchronous): state IDLE; in_ready=1; write=0; sel=0; num=0; busy=0; done=0; overflow=0; BCD register cleared.
- Outputs are Moore outputs, decoded from registered state only. No input-to-output combinational path exists.
- States:
  - IDLE: in_ready=1, busy=0. Acceptance occurs on a rising edge where in_valid&&in_ready.
    - On acceptance: latch in_data into the shift register, clear the BCD register and bit_cnt, and set overflow=(in_data>99_999_999).
    - Next state is CONV, or WRITE with idx=0 if the value overflowed.
  - CONV: runs BIN_W cycles. Each cycle:
    - For every BCD nibble >=5, add 3.
    - Then shift {bcd,bin} left by 1.
    - bit_cnt increments; after the cycle with bit_cnt==BIN_W-1, go to WRITE with idx=0.
  - WRITE: runs NUM_DIGITS cycles, one digit per cycle.
    - write=1, sel=idx, num=bcd[4*idx+:4]. If overflow is set, num=4'hE instead.
    - idx increments each cycle; after idx==NUM_DIGITS-1, go to DONE.
  - DONE: exactly one cycle; done=1, write=0. Then return to IDLE.
- Latency from the acceptance edge: 27 CONV cycles, 8 WRITE cycles, 1 DONE cycle. The first write is seen in cycle 28 and done in cycle 36.
- For an overflowing value, CONV is skipped: the first write is seen in cycle 1 and done in cycle 9.
- busy=1 in CONV, WRITE and DONE. in_ready=0 in those states, and in_valid is ignored while in_ready=0.
- overflow holds its value until the next acceptance or reset.
- Boundaries:
  - in_data=0 writes all zeros.
  - in_data=99_999_999 writes all 9s.
  - in_data=100_000_000 overflows.
  - Bits of in_data above bit 26 are part of the overflow compare.
- Reset mid-operation: write drops immediately (asynchronous). The digit sequence is abandoned; no partial completion and no done pulse.
- in_valid held high continuously: a new value is accepted on the first IDLE edge after DONE, so transactions run back-to-back with a 1-cycle IDLE gap.

Decomposition:
- Shared package lab6_pkg:
  - state enum {IDLE, CONV, WRITE, DONE}
  - constants NUM_DIGITS=8, BIN_W=27, MAX_VAL=99_999_999, OVF_DIGIT=4'hE
- One natural sub-module: dd_adjust, combinational. It applies the add-3-if->=5 rule to a NUM_DIGITS*4-bit BCD vector and is instantiated once in the CONV datapath.

Test Plan:
- Reset, then in_valid=1 with in_data=12_345_678 -> in_ready falls the next cycle. Writes start 28 cycles after acceptance with (sel,num) = (0,8),(1,7),(2,6),(3,5),(4,4),(5,3),(6,2),(7,1). done pulses in cycle 36; overflow=0.
- in_data=0 -> 8 writes of num=0. Then in_data=99_999_999 -> 8 writes of num=9; overflow=0 throughout.
- in_data=100_000_000 -> overflow=1 from cycle 1; writes in cycles 1-8, all num=4'hE with sel 0..7; done in cycle 9.
- in_valid held high with data 42, then changed to 7 during busy -> only 42 is converted (writes 2,4,0,0,0,0,0,0). Then 7 is accepted one cycle after done.
- Reset asserted in cycle 10 of CONV -> write stays 0, no done pulse, in_ready=1 immediately. A following in_data=5 converts correctly.
- Reset asserted during the third WRITE cycle -> write deasserts without waiting for a clock edge. sel=0, num=0 while reset is held.
